// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the data-memory port arbiter: access modes, widths
// and sequencer state encodings.
package mem_port_arbiter_pkg;

  localparam int WORD_W = 32;
  localparam int MODE_W = 2;

  localparam logic [MODE_W-1:0] MEM_BYTE = 2'd0;
  localparam logic [MODE_W-1:0] MEM_HALF = 2'd1;
  localparam logic [MODE_W-1:0] MEM_WORD = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

endpackage

// File: rtl/mem_port_arbiter_arbiter.sv
// Two-way round-robin grant: on a tie the requester that was not granted last
// wins; a lone requester always wins.
module rr_arbiter2 (
  input  logic       valid0,
  input  logic       valid1,
  input  logic       last_grant,
  output logic [1:0] grant,
  output logic       grant_id
);

  always_comb begin
    grant    = 2'b00;
    grant_id = 1'b0;
    if (valid0 && valid1) begin
      grant_id = ~last_grant;
    end else if (valid1) begin
      grant_id = 1'b1;
    end else begin
      grant_id = 1'b0;
    end
    if (valid0 || valid1) begin
      grant = grant_id ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin sequencer for the single-ported data memory: accepts one request
// from either requester, runs one memory cycle and returns a one-cycle response.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int                ADDR_W    = WORD_W,
  parameter logic [ADDR_W-1:0] MEM_LIMIT = 'hfffff
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              req0Valid,
  input  logic              req0Write,
  input  logic [ADDR_W-1:0] req0Addr,
  input  logic [ADDR_W-1:0] req0WData,
  input  logic [MODE_W-1:0] req0Mode,
  output logic              req0Ready,
  output logic              rsp0Valid,
  output logic [ADDR_W-1:0] rsp0RData,
  output logic              rsp0Err,

  input  logic              req1Valid,
  input  logic              req1Write,
  input  logic [ADDR_W-1:0] req1Addr,
  input  logic [ADDR_W-1:0] req1WData,
  input  logic [MODE_W-1:0] req1Mode,
  output logic              req1Ready,
  output logic              rsp1Valid,
  output logic [ADDR_W-1:0] rsp1RData,
  output logic              rsp1Err,

  output logic [ADDR_W-1:0] memAddress,
  output logic [ADDR_W-1:0] memWriteData,
  output logic [MODE_W-1:0] memMode,
  output logic              memRead,
  output logic              memWrite,
  input  logic [ADDR_W-1:0] memReadData
);

  state_t              state, next_state;
  logic                last_grant;
  logic [1:0]          grant;
  logic                grant_id;
  logic                accept;

  logic                sel_write;
  logic [ADDR_W-1:0]   sel_addr;
  logic [ADDR_W-1:0]   sel_wdata;
  logic [MODE_W-1:0]   sel_mode;
  logic [ADDR_W:0]     last_byte;
  logic                misaligned;
  logic                bad_mode;
  logic                sel_err;

  logic                lat_write;
  logic                lat_id;
  logic                lat_err;
  logic [ADDR_W-1:0]   rdata_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [ADDR_W-1:0]   wdata_q;
  logic [MODE_W-1:0]   mode_q;

  rr_arbiter2 u_arb (
    .valid0     (req0Valid),
    .valid1     (req1Valid),
    .last_grant (last_grant),
    .grant      (grant),
    .grant_id   (grant_id)
  );

  assign accept    = (state == ST_IDLE) && (grant != 2'b00);
  assign sel_write = grant_id ? req1Write : req0Write;
  assign sel_addr  = grant_id ? req1Addr  : req0Addr;
  assign sel_wdata = grant_id ? req1WData : req0WData;
  assign sel_mode  = grant_id ? req1Mode  : req0Mode;

  // Last touched byte is formed one bit wider so an access near the top of
  // the address space cannot wrap around and slip under the limit.
  always_comb begin
    last_byte  = {1'b0, sel_addr};
    misaligned = 1'b0;
    bad_mode   = 1'b0;
    case (sel_mode)
      MEM_BYTE: last_byte = {1'b0, sel_addr};
      MEM_HALF: begin
        last_byte  = {1'b0, sel_addr} + (ADDR_W+1)'(1);
        misaligned = sel_addr[0];
      end
      MEM_WORD: begin
        last_byte  = {1'b0, sel_addr} + (ADDR_W+1)'(3);
        misaligned = |sel_addr[1:0];
      end
      default: bad_mode = 1'b1;
    endcase
    sel_err = misaligned | bad_mode | (last_byte > {1'b0, MEM_LIMIT});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:  if (accept) next_state = sel_err ? ST_RESP : ST_ISSUE;
      ST_ISSUE: next_state = ST_RESP;
      ST_RESP:  next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    req0Ready = 1'b0;
    req1Ready = 1'b0;
    memRead   = 1'b0;
    memWrite  = 1'b0;
    rsp0Valid = 1'b0;
    rsp0RData = '0;
    rsp0Err   = 1'b0;
    rsp1Valid = 1'b0;
    rsp1RData = '0;
    rsp1Err   = 1'b0;
    case (state)
      ST_IDLE: begin
        req0Ready = grant[0];
        req1Ready = grant[1];
      end
      ST_ISSUE: begin
        memWrite = lat_write;
        memRead  = ~lat_write;
      end
      ST_RESP: begin
        if (lat_id) begin
          rsp1Valid = 1'b1;
          rsp1RData = rdata_q;
          rsp1Err   = lat_err;
        end else begin
          rsp0Valid = 1'b1;
          rsp0RData = rdata_q;
          rsp0Err   = lat_err;
        end
      end
      default: ;
    endcase
  end

  // The memory-facing registers only load for good accesses, so the port keeps
  // showing the last real access while idle or while an error is answered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
      lat_write  <= 1'b0;
      lat_id     <= 1'b0;
      lat_err    <= 1'b0;
      rdata_q    <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      mode_q     <= '0;
    end else if (accept) begin
      last_grant <= grant_id;
      lat_write  <= sel_write;
      lat_id     <= grant_id;
      lat_err    <= sel_err;
      rdata_q    <= '0;
      if (!sel_err) begin
        addr_q  <= sel_addr;
        wdata_q <= sel_wdata;
        mode_q  <= sel_mode;
      end
    end else if (state == ST_ISSUE) begin
      rdata_q <= lat_write ? '0 : memReadData;
    end
  end

  assign memAddress   = addr_q;
  assign memWriteData = wdata_q;
  assign memMode      = mode_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios followed by a
// randomized two-requester run checked against a byte-level reference memory.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam logic [31:0] LIMIT = 32'hfffff;

  logic        clk;
  logic        rst_n;
  logic        req0Valid, req0Write, req0Ready, rsp0Valid, rsp0Err;
  logic [31:0] req0Addr, req0WData, rsp0RData;
  logic [1:0]  req0Mode;
  logic        req1Valid, req1Write, req1Ready, rsp1Valid, rsp1Err;
  logic [31:0] req1Addr, req1WData, rsp1RData;
  logic [1:0]  req1Mode;
  logic [31:0] memAddress, memWriteData, memReadData;
  logic [1:0]  memMode;
  logic        memRead, memWrite;

  int total = 0;
  int bad   = 0;

  logic [7:0]  mem [0:4095];
  logic [7:0]  ref_mem [logic [31:0]];
  logic [11:0] ma0, ma1, ma2, ma3;

  mem_port_arbiter #(.ADDR_W(32), .MEM_LIMIT(LIMIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0Valid(req0Valid), .req0Write(req0Write), .req0Addr(req0Addr),
    .req0WData(req0WData), .req0Mode(req0Mode), .req0Ready(req0Ready),
    .rsp0Valid(rsp0Valid), .rsp0RData(rsp0RData), .rsp0Err(rsp0Err),
    .req1Valid(req1Valid), .req1Write(req1Write), .req1Addr(req1Addr),
    .req1WData(req1WData), .req1Mode(req1Mode), .req1Ready(req1Ready),
    .rsp1Valid(rsp1Valid), .rsp1RData(rsp1RData), .rsp1Err(rsp1Err),
    .memAddress(memAddress), .memWriteData(memWriteData), .memMode(memMode),
    .memRead(memRead), .memWrite(memWrite), .memReadData(memReadData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Big-endian byte memory: write at negedge, combinational read.
  assign ma0 = memAddress[11:0];
  assign ma1 = ma0 + 12'd1;
  assign ma2 = ma0 + 12'd2;
  assign ma3 = ma0 + 12'd3;

  always @(negedge clk) begin
    if (memWrite) begin
      case (memMode)
        2'd0: mem[ma0] <= memWriteData[7:0];
        2'd1: begin
          mem[ma0] <= memWriteData[15:8];
          mem[ma1] <= memWriteData[7:0];
        end
        default: begin
          mem[ma0] <= memWriteData[31:24];
          mem[ma1] <= memWriteData[23:16];
          mem[ma2] <= memWriteData[15:8];
          mem[ma3] <= memWriteData[7:0];
        end
      endcase
    end
  end

  always_comb begin
    case (memMode)
      2'd0:    memReadData = {24'h0, mem[ma0]};
      2'd1:    memReadData = {16'h0, mem[ma0], mem[ma1]};
      default: memReadData = {mem[ma0], mem[ma1], mem[ma2], mem[ma3]};
    endcase
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog expired observed=timeout required=finish");
    $fatal(1, "[TB] watchdog");
  end

  function automatic int size_of(input logic [1:0] mode);
    return (mode == 2'd0) ? 1 : (mode == 2'd1) ? 2 : 4;
  endfunction

  function automatic bit ref_err(input logic [31:0] addr, input logic [1:0] mode);
    int n;
    if (mode == 2'd3) return 1'b1;
    n = size_of(mode);
    if ((addr % n) != 0) return 1'b1;
    return ({32'h0, addr} + 64'(n) - 64'd1) > {32'h0, LIMIT};
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] addr, input logic [1:0] mode);
    logic [31:0] v = 32'h0;
    logic [31:0] a;
    for (int i = 0; i < size_of(mode); i++) begin
      a = addr + 32'(i);
      v = (v << 8) | (ref_mem.exists(a) ? 32'(ref_mem[a]) : 32'h0);
    end
    return v;
  endfunction

  task automatic ref_write(input logic [31:0] addr, input logic [31:0] wdata, input logic [1:0] mode);
    int n = size_of(mode);
    for (int i = 0; i < n; i++) ref_mem[addr + 32'(i)] = 8'(wdata >> (8 * (n - 1 - i)));
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 3))
      0, 1:    return 32'h100 + 32'($urandom_range(0, 15));
      2:       return LIMIT - 32'($urandom_range(0, 7));
      default: return 32'hFFFFFFF0 + 32'($urandom_range(0, 15));
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic set_req(input int id, input bit v, input bit wr, input logic [31:0] a,
                         input logic [31:0] d, input logic [1:0] m);
    if (id == 0) begin
      req0Valid = v; req0Write = wr; req0Addr = a; req0WData = d; req0Mode = m;
    end else begin
      req1Valid = v; req1Write = wr; req1Addr = a; req1WData = d; req1Mode = m;
    end
  endtask

  task automatic check_quiet(input string tag);
    checkOutput({tag, "_ready"}, {30'h0, req1Ready, req0Ready}, 32'h0);
    checkOutput({tag, "_rsp"}, {28'h0, rsp1Valid, rsp1Err, rsp0Valid, rsp0Err}, 32'h0);
    checkOutput({tag, "_rdata0"}, rsp0RData, 32'h0);
    checkOutput({tag, "_rdata1"}, rsp1RData, 32'h0);
    checkOutput({tag, "_mem_addr"}, memAddress, 32'h0);
    checkOutput({tag, "_mem_wdata"}, memWriteData, 32'h0);
    checkOutput({tag, "_mem_ctl"}, {28'h0, memMode, memRead, memWrite}, 32'h0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    set_req(0, 0, 0, 0, 0, 0);
    set_req(1, 0, 0, 0, 0, 0);
    @(negedge clk);
    check_quiet("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // One isolated access from IDLE, checked cycle by cycle; called at posedge+1.
  task automatic applyStimulus(input int id, input bit wr, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [1:0] mode);
    bit          e;
    logic [31:0] exp_rd;
    e      = ref_err(addr, mode);
    exp_rd = (e || wr) ? 32'h0 : ref_read(addr, mode);
    set_req(id, 1, wr, addr, wdata, mode);
    @(negedge clk);
    checkOutput("acc_ready", {30'h0, req1Ready, req0Ready}, (id == 1) ? 32'h2 : 32'h1);
    checkOutput("acc_mem_idle", {30'h0, memRead, memWrite}, 32'h0);
    @(posedge clk);
    #1 set_req(id, 0, 0, 0, 0, 0);
    if (!e) begin
      @(negedge clk);
      checkOutput("iss_write", memWrite, wr);
      checkOutput("iss_read", memRead, !wr);
      checkOutput("iss_addr", memAddress, addr);
      checkOutput("iss_mode", memMode, mode);
      if (wr) checkOutput("iss_wdata", memWriteData, wdata);
      checkOutput("iss_no_rsp", {30'h0, rsp1Valid, rsp0Valid}, 32'h0);
      checkOutput("iss_no_ready", {30'h0, req1Ready, req0Ready}, 32'h0);
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    checkOutput("rsp_valid", {30'h0, rsp1Valid, rsp0Valid}, (id == 1) ? 32'h2 : 32'h1);
    checkOutput("rsp_err", (id == 1) ? rsp1Err : rsp0Err, e);
    checkOutput("rsp_rdata", (id == 1) ? rsp1RData : rsp0RData, exp_rd);
    checkOutput("rsp_mem_idle", {30'h0, memRead, memWrite}, 32'h0);
    if (!e) checkOutput("rsp_addr_hold", memAddress, addr);
    if (!e && wr) ref_write(addr, wdata, mode);
    @(posedge clk);
    #1;
  endtask

  bit          pend [2];
  bit          p_wr [2];
  logic [31:0] p_addr [2];
  logic [31:0] p_wd [2];
  logic [1:0]  p_mode [2];

  initial begin
    int          exp_w, waited, win, last_g, free_cyc, rsp_cyc, iss_cyc, rsp_id;
    bit          e, rsp_err, iss_wr;
    logic [31:0] rsp_rd, iss_addr;
    logic [1:0]  iss_mode;

    $display("[TB] start");
    do_reset();

    // Basic store/load round trip and big-endian sub-word reads.
    applyStimulus(0, 1, 32'h100, 32'hDEADBEEF, MEM_WORD);
    applyStimulus(0, 0, 32'h100, 32'h0, MEM_WORD);
    applyStimulus(0, 0, 32'h102, 32'h0, MEM_HALF);
    applyStimulus(1, 0, 32'h101, 32'h0, MEM_WORD);
    applyStimulus(1, 1, 32'h101, 32'hFFFFFF77, MEM_BYTE);
    applyStimulus(0, 0, 32'h100, 32'h0, MEM_WORD);
    applyStimulus(1, 0, 32'h101, 32'h0, MEM_BYTE);

    applyStimulus(1, 1, 32'h104, 32'h01234567, MEM_WORD);
    applyStimulus(0, 1, 32'h108, 32'h89ABCDEF, MEM_WORD);
    applyStimulus(1, 1, 32'h10C, 32'hCAFEF00D, MEM_WORD);
    applyStimulus(0, 1, LIMIT - 32'd7, 32'h5A5AA5A5, MEM_WORD);

    // Range and alignment boundaries.
    applyStimulus(0, 1, LIMIT - 32'd3, 32'h0BADC0DE, MEM_WORD);
    applyStimulus(1, 0, LIMIT - 32'd3, 32'h0, MEM_WORD);
    applyStimulus(0, 0, LIMIT - 32'd1, 32'h0, MEM_WORD);
    applyStimulus(0, 0, LIMIT + 32'd1, 32'h0, MEM_WORD);
    applyStimulus(1, 0, LIMIT - 32'd1, 32'h0, MEM_HALF);
    applyStimulus(1, 0, LIMIT, 32'h0, MEM_HALF);
    applyStimulus(0, 0, LIMIT, 32'h0, MEM_BYTE);
    applyStimulus(0, 1, LIMIT + 32'd1, 32'h55, MEM_BYTE);
    applyStimulus(1, 0, 32'hFFFFFFFF, 32'h0, MEM_BYTE);
    applyStimulus(0, 0, 32'h100, 32'h0, 2'd3);

    // A request raised while busy and withdrawn before IDLE is never served.
    set_req(1, 1, 0, 32'h100, 32'h0, MEM_WORD);
    @(negedge clk);
    checkOutput("drop_acc1", req1Ready, 1'b1);
    @(posedge clk);
    #1 set_req(1, 0, 0, 0, 0, 0);
    set_req(0, 1, 1, 32'h108, 32'h11111111, MEM_WORD);
    @(negedge clk);
    checkOutput("drop_issue_ready0", req0Ready, 1'b0);
    checkOutput("drop_issue_read", memRead, 1'b1);
    @(negedge clk);
    checkOutput("drop_resp_ready0", req0Ready, 1'b0);
    checkOutput("drop_resp_valid1", rsp1Valid, 1'b1);
    #1 set_req(0, 0, 0, 0, 0, 0);
    repeat (4) begin
      @(negedge clk);
      checkOutput("drop_no_mem", {30'h0, memRead, memWrite}, 32'h0);
      checkOutput("drop_no_rsp", {30'h0, rsp1Valid, rsp0Valid}, 32'h0);
      checkOutput("drop_no_ready", {30'h0, req1Ready, req0Ready}, 32'h0);
    end
    @(posedge clk);
    #1;
    applyStimulus(0, 0, 32'h108, 32'h0, MEM_WORD);

    // Both requesters continuously valid: strict alternation starting at 0.
    do_reset();
    set_req(0, 1, 0, 32'h100, 32'h0, MEM_WORD);
    set_req(1, 1, 0, 32'h104, 32'h0, MEM_WORD);
    exp_w = 0;
    for (int r = 0; r < 6; r++) begin
      waited = 0;
      @(negedge clk);
      while (!(req0Ready || req1Ready) && waited < 4) begin
        @(negedge clk);
        waited++;
      end
      checkOutput("arb_grant", {30'h0, req1Ready, req0Ready}, (exp_w == 1) ? 32'h2 : 32'h1);
      if (!(req0Ready || req1Ready)) break;
      checkOutput("arb_gap", waited, 0);
      @(negedge clk);
      @(negedge clk);
      checkOutput("arb_rsp_valid", {30'h0, rsp1Valid, rsp0Valid}, (exp_w == 1) ? 32'h2 : 32'h1);
      checkOutput("arb_rsp_data", (exp_w == 1) ? rsp1RData : rsp0RData,
                  ref_read((exp_w == 1) ? 32'h104 : 32'h100, MEM_WORD));
      exp_w = 1 - exp_w;
    end
    #1 set_req(0, 0, 0, 0, 0, 0);
    set_req(1, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;

    // Reset during ISSUE abandons the load; the grant history is cleared too.
    set_req(0, 1, 0, 32'h100, 32'h0, MEM_WORD);
    @(negedge clk);
    checkOutput("rst_acc", req0Ready, 1'b1);
    @(posedge clk);
    #1 set_req(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("rst_issue_read", memRead, 1'b1);
    #2 rst_n = 1'b0;
    #1 check_quiet("rst_async");
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checkOutput("rst_no_rsp", {30'h0, rsp1Valid, rsp0Valid}, 32'h0);
      checkOutput("rst_no_mem", {30'h0, memRead, memWrite}, 32'h0);
    end
    @(posedge clk);
    #1;
    set_req(0, 1, 0, 32'h100, 32'h0, MEM_WORD);
    set_req(1, 1, 0, 32'h104, 32'h0, MEM_WORD);
    @(negedge clk);
    checkOutput("rst_tie_grant", {30'h0, req1Ready, req0Ready}, 32'h1);
    @(posedge clk);
    #1 set_req(0, 0, 0, 0, 0, 0);
    set_req(1, 0, 0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_tie_rsp", {30'h0, rsp1Valid, rsp0Valid}, 32'h1);
    checkOutput("rst_tie_data", rsp0RData, ref_read(32'h100, MEM_WORD));
    @(posedge clk);
    #1;

    // Randomized traffic against the transaction-level model.
    do_reset();
    last_g = 1; free_cyc = 0; rsp_cyc = -1; iss_cyc = -1; rsp_id = 0;
    rsp_err = 0; rsp_rd = 0; iss_wr = 0; iss_addr = 0; iss_mode = 0;
    pend[0] = 0; pend[1] = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int i = 0; i < 2; i++) begin
        if (!pend[i] && $urandom_range(0, 3) != 0) begin
          pend[i]   = 1'b1;
          p_wr[i]   = 1'($urandom_range(0, 1));
          p_mode[i] = 2'($urandom_range(0, 3));
          p_wd[i]   = $urandom;
          p_addr[i] = rand_addr();
        end
        set_req(i, pend[i], p_wr[i], p_addr[i], p_wd[i], p_mode[i]);
      end
      @(negedge clk);
      win = -1;
      if (cyc >= free_cyc && (pend[0] || pend[1])) begin
        if (pend[0] && pend[1]) win = (last_g == 1) ? 0 : 1;
        else                    win = pend[1] ? 1 : 0;
        e        = ref_err(p_addr[win], p_mode[win]);
        rsp_id   = win;
        rsp_err  = e;
        rsp_rd   = (e || p_wr[win]) ? 32'h0 : ref_read(p_addr[win], p_mode[win]);
        if (!e && p_wr[win]) ref_write(p_addr[win], p_wd[win], p_mode[win]);
        rsp_cyc  = cyc + (e ? 1 : 2);
        free_cyc = cyc + (e ? 2 : 3);
        if (!e) begin
          iss_cyc  = cyc + 1;
          iss_wr   = p_wr[win];
          iss_addr = p_addr[win];
          iss_mode = p_mode[win];
        end
        last_g = win;
      end
      checkOutput("rnd_ready0", req0Ready, win == 0);
      checkOutput("rnd_ready1", req1Ready, win == 1);
      checkOutput("rnd_mem_write", memWrite, (cyc == iss_cyc) && iss_wr);
      checkOutput("rnd_mem_read", memRead, (cyc == iss_cyc) && !iss_wr);
      if (cyc == iss_cyc) begin
        checkOutput("rnd_mem_addr", memAddress, iss_addr);
        checkOutput("rnd_mem_mode", memMode, iss_mode);
      end
      checkOutput("rnd_rsp0_valid", rsp0Valid, (cyc == rsp_cyc) && (rsp_id == 0));
      checkOutput("rnd_rsp1_valid", rsp1Valid, (cyc == rsp_cyc) && (rsp_id == 1));
      if (cyc == rsp_cyc) begin
        checkOutput("rnd_rsp_err", (rsp_id == 1) ? rsp1Err : rsp0Err, rsp_err);
        checkOutput("rnd_rsp_rdata", (rsp_id == 1) ? rsp1RData : rsp0RData, rsp_rd);
      end
      @(posedge clk);
      #1;
      if (win >= 0) pend[win] = 1'b0;
    end
    set_req(0, 0, 0, 0, 0, 0);
    set_req(1, 0, 0, 0, 0, 0);
    repeat (4) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
